// File: rtl/div_float_seq.sv
// div_float_seq: sequential IEEE-754 single-precision divider.
// Restoring division (one quotient bit per cycle), truncating, denormals flushed to zero.
module div_float_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dnd,
    input  logic [31:0] der,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ITER, NORM, SPEC} state_t;
    state_t state_q, state_d;
    logic              s_q, s_d, err_q, err_d, done_q, done_d;
    logic [7:0]        ea_q, ea_d, eb_q, eb_d;
    logic signed [9:0] e_q, e_d, en;
    logic [23:0]       m2_q, m2_d;
    logic [25:0]       r_q, r_d, diff;
    logic [24:0]       q_q, q_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       quo_q, quo_d;
    logic [22:0]       man;
    logic              ge, special;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            e_q     <= '0;
            m2_q    <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            e_q     <= e_d;
            m2_q    <= m2_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign special = dnd[30:23] == 8'd0 || dnd[30:23] == 8'd255 ||
                     der[30:23] == 8'd0 || der[30:23] == 8'd255;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = special ? SPEC : ITER;
            ITER:    if (cnt_q == 5'd24) state_d = NORM;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = done_q;
        quo  = quo_q;
        err  = err_q;
    end

    // A leading quotient bit of 0 means the quotient is in [0.5,1): shift once more.
    assign diff = r_q - {2'b00, m2_q};
    assign ge   = r_q >= {2'b00, m2_q};
    assign man  = q_q[24] ? q_q[23:1] : q_q[22:0];
    assign en   = q_q[24] ? e_q : e_q - 10'sd1;

    always_comb begin
        s_d    = s_q;
        ea_d   = ea_q;
        eb_d   = eb_q;
        e_d    = e_q;
        m2_d   = m2_q;
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        err_d  = err_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                s_d   = dnd[31] ^ der[31];
                ea_d  = dnd[30:23];
                eb_d  = der[30:23];
                e_d   = $signed({2'b00, dnd[30:23]}) - $signed({2'b00, der[30:23]}) + 10'sd127;
                m2_d  = {1'b1, der[22:0]};
                r_d   = {3'b001, dnd[22:0]};
                q_d   = '0;
                cnt_d = '0;
            end
            ITER: begin
                r_d   = ge ? diff << 1 : r_q << 1;
                q_d   = {q_q[23:0], ge};
                cnt_d = cnt_q == 5'd24 ? 5'd0 : cnt_q + 5'd1;
            end
            NORM: begin
                done_d = 1'b1;
                err_d  = en >= 10'sd255 || en <= 10'sd0;
                quo_d  = en >= 10'sd255 ? {s_q, 8'hFF, 23'd0} :
                         en <= 10'sd0   ? {s_q, 31'd0} : {s_q, en[7:0], man};
            end
            default: begin
                done_d = 1'b1;
                err_d  = ea_q == 8'd255 || eb_q == 8'd255 || eb_q == 8'd0;
                quo_d  = (ea_q == 8'd255 || eb_q == 8'd255) ? 32'h7FC00000 :
                         eb_q == 8'd0 ? {s_q, 8'hFF, 23'd0} : {s_q, 31'd0};
            end
        endcase
    end
endmodule

// File: tb/tb_div_float_seq.sv
// tb_div_float_seq: directed checks of div_float_seq against hand-computed quotients and latencies.
module tb_div_float_seq;
    logic        clk = 1'b0, rst, start;
    logic [31:0] dnd, der, quo;
    logic        busy, done, err;
    int          compared = 0, mismatched = 0;

    div_float_seq dut (
        .clk(clk), .rst(rst), .start(start), .dnd(dnd), .der(der),
        .busy(busy), .done(done), .quo(quo), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: plain run; mode 1: new start pulsed at edge N+10; mode 2: reset at edge N+12
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic exp_err, input int exp_lat,
                       input int mode);
        int k;
        int extra;
        logic bad_busy;
        dnd = a;
        der = b;
        start = 1'b1;
        @(posedge clk);
        k = 0;
        bad_busy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!done && k < 40) begin
            if (!busy) bad_busy = 1'b1;
            if (mode == 1 && k == 9) begin
                start = 1'b1;
                dnd = 32'h3F800000;
                der = 32'h40400000;
            end
            if (mode == 1 && k == 10) start = 1'b0;
            if (mode == 2 && k == 11) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_quo"}, quo, 0);
                chk({tag, "_rst_err"}, err, 0);
                return;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_quo"}, quo, exp_q);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_low_at_done"}, busy, 0);
        chk({tag, "_busy_high_while_running"}, bad_busy, 0);
        if (mode == 1) begin
            extra = 0;
            repeat (35) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({tag, "_no_second_done"}, extra, 0);
            chk({tag, "_quo_held"}, quo, exp_q);
        end
    endtask

    initial begin
        int late_done;
        rst = 1'b1;
        start = 1'b0;
        dnd = '0;
        der = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quo", quo, 0);
        chk("reset_err", err, 0);
        start = 1'b1;
        dnd = 32'h3F800000;
        der = 32'h00000000;
        @(posedge clk);
        @(negedge clk);
        chk("rst_beats_start_busy", busy, 0);
        chk("rst_beats_start_done", done, 0);
        rst = 1'b0;
        run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 0);
        run("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        run("neg_1p5_by_0p5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 26, 0);
        run("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0);
        run("negone_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1, 0);
        run("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1, 0);
        run("zero_by_two", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1, 0);
        run("negzero_by_two", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1, 0);
        run("inf_by_one", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1, 0);
        run("one_by_inf_zero_prio", 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1, 0);
        run("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 26, 0);
        run("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 26, 0);
        run("ignore_start", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 1);
        run("abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, 2);
        late_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("abort_no_done", late_done, 0);
        rst = 1'b0;
        run("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/div_float_seq.md
DIV_FLOAT_SEQ -- requirements
Module: div_float_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port dnd, input, 32 bits: IEEE-754 single dividend; captured on the accepting edge.
REQ-005 SHALL have port der, input, 32 bits: IEEE-754 single divisor; captured on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when quo and err are valid.
REQ-008 SHALL have port quo, output, 32 bits: quotient; holds its value until the next done.
REQ-009 SHALL have port err, output, 1 bit: exception flag; updated with quo.

Function
REQ-010 SHALL implement FSM states IDLE, ITER, NORM and SPEC.
REQ-011 SHALL accept a request when state is IDLE and start=1 at a rising edge (edge N), capturing dnd and der; start in any other state SHALL be ignored, with no queueing.
REQ-012 SHALL compute sign s = dnd[31] XOR der[31]; exponent e = e1 - e2 + 127, held in a signed register of at least 10 bits; mantissas m1 = {1,dnd[22:0]} and m2 = {1,der[22:0]}.
REQ-013 SHALL classify operands at edge N: an exponent field of 0 is zero (denormals flushed); an exponent field of 255 is inf/NaN; a class other than normal SHALL go to SPEC.
REQ-014 SPEC results, highest priority first:
- either exponent = 255: quo = 0x7FC00000, err = 1.
- der is zero, including 0/0: quo = {s, 0xFF, 23'b0}, err = 1.
- dnd is zero: quo = {s, 31'b0}, err = 0.
REQ-015 SHALL deliver the SPEC result on edge N+1, with done high for that one cycle, then return to IDLE.
REQ-016 ITER SHALL perform restoring division, one quotient bit per cycle, for 25 cycles on edges N+1..N+25:
- the remainder R (26 bits) is initialised to m1;
- each step: if R >= m2 then the bit is 1 and R = (R - m2) << 1; else the bit is 0 and R = R << 1.
- bits are shifted MSB-first into q[24:0].
REQ-017 SHALL use a 5-bit iteration counter that wraps to 0 on leaving ITER.
REQ-018 NORM (edge N+26) SHALL normalise the quotient, with no rounding (truncate):
- if q[24] = 1: mantissa = q[23:1] and e is unchanged;
- else: mantissa = q[22:0] and e = e - 1.
REQ-019 NORM SHALL write the output on edge N+26: if e >= 255, quo = {s, 0xFF, 0} and err = 1; if e <= 0, quo = {s, 31'b0} and err = 1; else quo = {s, e[7:0], mantissa} and err = 0.
REQ-020 done SHALL be high only in the cycle following the edge that writes quo/err.
REQ-021 The next start SHALL be acceptable on the edge immediately after done.
REQ-022 Input changes after edge N SHALL NOT affect the result.
REQ-023 busy SHALL fall on the same edge that raises done.

Reset
REQ-024 On rst=1 at a rising edge, the FSM SHALL go to IDLE and quo, err, done and busy SHALL go to 0; counter, remainder and quotient registers SHALL clear.
REQ-025 Reset mid-operation SHALL abort silently, with no done pulse.
REQ-026 rst SHALL take priority over a simultaneous start.
REQ-027 The first accepted start after reset is released SHALL be on the first edge with rst=0.

Verification
REQ-028 6.0/2.0: 0x40C00000 / 0x40000000 -> quo = 0x40400000, err = 0; done exactly 26 edges after the accept edge; busy high throughout.
REQ-029 1.0/3.0: 0x3F800000 / 0x40400000 -> quo = 0x3EAAAAAA, err = 0 (truncation checked). Also -1.5/0.5: 0xBFC00000 / 0x3F000000 -> quo = 0xC0400000.
REQ-030 Special cases, each with done one edge after accept:
- 0x3F800000 / 0x00000000 -> quo = 0x7F800000, err = 1;
- 0x00000000 / 0x40000000 -> quo = 0x00000000, err = 0;
- 0x7F800000 / 0x3F800000 -> quo = 0x7FC00000, err = 1.
REQ-031 Range errors:
- overflow: 0x7F000000 / 0x00800000 -> quo = 0x7F800000, err = 1;
- underflow: 0x00800000 / 0x7F000000 -> quo = 0x00000000, err = 1.
REQ-032 Start pulsed with new operands at edge N+10 of an active division -> ignored; the first result is unchanged; no second done.
REQ-033 rst asserted at edge N+12 -> all outputs 0, no done; a new start on the first edge with rst=0 then gives a correct result with the 26-edge latency.
